// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and data-cache controller states.
package cpu_types_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        WRITE  = 2'd2,
        HALTED = 2'd3
    } dcache_state_t;
endpackage

// File: rtl/dcache_wt_if.sv
// Datapath-side and memory-side signals of the write-through data cache.
interface dcache_wt_if;
    import cpu_types_pkg::*;

    // datapath side
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  halt;
    logic  dhit;
    word_t dmemload;
    logic  flushed;
    // memory controller side
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    word_t dload;
    logic  dwait;
    // statistics
    word_t hit_count;
    word_t miss_count;

    // cache side
    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore,
               hit_count, miss_count
    );

    // datapath / memory side
    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
        input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore,
               hit_count, miss_count
    );
endinterface

// File: rtl/dcache_wt_frames.sv
// NSETS one-word frames: combinational read, single synchronous write,
// synchronous clear of every frame on RST.
module dcache_frames
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16,
    parameter int IDX   = $clog2(NSETS),
    parameter int TAGW  = 30 - IDX
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [IDX-1:0]  i_ridx,
    output logic            o_rvalid,
    output logic [TAGW-1:0] o_rtag,
    output word_t           o_rdata,
    input  logic            i_we,
    input  logic [IDX-1:0]  i_widx,
    input  logic [TAGW-1:0] i_wtag,
    input  word_t           i_wdata
);
    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] tag;
        word_t           data;
    } frame_t;

    frame_t r_frames [NSETS];

    // clear has priority over a fill/update in the same cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NSETS; i++) r_frames[i] <= '0;
        end else if (i_we) begin
            r_frames[i_widx] <= '{valid: 1'b1, tag: i_wtag, data: i_wdata};
        end
    end

    assign o_rvalid = r_frames[i_ridx].valid;
    assign o_rtag   = r_frames[i_ridx].tag;
    assign o_rdata  = r_frames[i_ridx].data;
endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// single-outstanding memory port and halt drain.
module dcache_wt
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  logic         CLK,
    input  logic         RST,
    dcache_wt_if.slave   bus
);
    localparam int IDX  = $clog2(NSETS);
    localparam int TAGW = 30 - IDX;

    dcache_state_t   r_state, w_next;
    word_t           r_addr, r_store, r_hits, r_misses;

    logic            w_latch_addr, w_latch_store, w_hit_inc, w_miss_inc;
    logic [IDX-1:0]  w_ridx;
    logic            w_fvalid;
    logic [TAGW-1:0] w_ftag;
    word_t           w_fdata;
    logic            w_we;
    word_t           w_wdata;
    logic            w_req_hit, w_lat_match;

    // In IDLE the frame lookup follows the live request; otherwise it follows
    // the latched address so WRITE can test for a resident copy.
    assign w_ridx      = (r_state == IDLE) ? bus.dmemaddr[IDX+1:2] : r_addr[IDX+1:2];
    assign w_req_hit   = w_fvalid && (w_ftag == bus.dmemaddr[31:IDX+2]);
    assign w_lat_match = w_fvalid && (w_ftag == r_addr[31:IDX+2]);

    dcache_frames #(.NSETS(NSETS)) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .i_ridx   (w_ridx),
        .o_rvalid (w_fvalid),
        .o_rtag   (w_ftag),
        .o_rdata  (w_fdata),
        .i_we     (w_we),
        .i_widx   (r_addr[IDX+1:2]),
        .i_wtag   (r_addr[31:IDX+2]),
        .i_wdata  (w_wdata)
    );

    // next state, datapath/memory handshakes and frame write control
    always_comb begin
        w_next        = r_state;
        w_latch_addr  = 1'b0;
        w_latch_store = 1'b0;
        w_hit_inc     = 1'b0;
        w_miss_inc    = 1'b0;
        w_we          = 1'b0;
        w_wdata       = r_store;
        bus.dhit      = 1'b0;
        bus.dmemload  = '0;
        bus.dREN      = 1'b0;
        bus.dWEN      = 1'b0;
        bus.flushed   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.dmemWEN) begin
                    w_latch_addr  = 1'b1;
                    w_latch_store = 1'b1;
                    w_next        = WRITE;
                end else if (bus.dmemREN) begin
                    if (w_req_hit) begin
                        bus.dhit     = 1'b1;
                        bus.dmemload = w_fdata;
                        w_hit_inc    = 1'b1;
                    end else begin
                        w_latch_addr = 1'b1;
                        w_miss_inc   = 1'b1;
                        w_next       = LOAD;
                    end
                end else if (bus.halt) begin
                    w_next = HALTED;
                end
            end
            LOAD: begin
                bus.dREN = 1'b1;
                if (!bus.dwait) begin
                    bus.dhit     = 1'b1;
                    bus.dmemload = bus.dload;
                    w_we         = 1'b1;
                    w_wdata      = bus.dload;
                    w_next       = IDLE;
                end
            end
            WRITE: begin
                bus.dWEN = 1'b1;
                if (!bus.dwait) begin
                    bus.dhit = 1'b1;
                    // update only a resident copy; misses do not allocate
                    w_we     = w_lat_match;
                    w_next   = IDLE;
                end
            end
            HALTED: bus.flushed = 1'b1;
            default: w_next = IDLE;
        endcase
    end

    // state, request latches and read statistics
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_store  <= '0;
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch_addr)  r_addr   <= bus.dmemaddr;
            if (w_latch_store) r_store  <= bus.dmemstore;
            if (w_hit_inc)     r_hits   <= r_hits + 32'd1;
            if (w_miss_inc)    r_misses <= r_misses + 32'd1;
        end
    end

    assign bus.daddr      = r_addr;
    assign bus.dstore     = r_store;
    assign bus.hit_count  = r_hits;
    assign bus.miss_count = r_misses;
endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus random
// read/write traffic against a set/tag/memory reference model.
module tb_dcache_wt;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    dcache_wt_if bus ();

    dcache_wt #(.NSETS(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;

    // reference model: 16 sets of {valid, tag}, backing memory by word index
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    word_t       m_mem   [int];
    word_t       m_hits  = '0;
    word_t       m_miss  = '0;

    function automatic word_t mem_rd(input word_t a);
        int k;
        k = int'(a >> 2);
        if (m_mem.exists(k)) return m_mem[k];
        return (a >> 2) * 32'h9E37_79B1 + 32'd1;
    endfunction

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
        end
        m_hits = '0;
        m_miss = '0;
    endtask

    // one complete request; memory answers after lat busy cycles on a miss/write
    task automatic do_req(input bit wr, input word_t a, input word_t d, input int lat);
        bit [3:0]    idx;
        logic [25:0] tg;
        bit          hit;
        idx = a[5:2];
        tg  = a[31:6];
        hit = !wr && m_valid[idx] && (m_tag[idx] == tg);
        @(posedge CLK); #1;
        bus.dmemREN   = !wr;
        bus.dmemWEN   = wr;
        bus.dmemaddr  = a;
        bus.dmemstore = d;
        bus.dwait     = 1'b1;
        bus.dload     = mem_rd(a);
        @(negedge CLK);
        if (hit) begin
            chk1("hit_dhit", bus.dhit, 1'b1);
            chk("hit_data", bus.dmemload, mem_rd(a));
            chk1("hit_dREN", bus.dREN, 1'b0);
            m_hits++;
        end else begin
            chk1("req_cycle_dhit", bus.dhit, 1'b0);
            if (!wr) m_miss++;
            @(posedge CLK); #1;
            for (int n = 0; n <= lat; n++) begin
                bus.dwait = (n < lat);
                @(negedge CLK);
                chk1("mem_dREN", bus.dREN, !wr);
                chk1("mem_dWEN", bus.dWEN, wr);
                chk("mem_daddr", bus.daddr, a);
                chk1("mem_dhit", bus.dhit, n == lat);
                if (wr) chk("mem_dstore", bus.dstore, d);
                if (!wr && n == lat) chk("miss_data", bus.dmemload, mem_rd(a));
                if (n < lat) begin
                    @(posedge CLK); #1;
                end
            end
            if (wr) begin
                m_mem[int'(a >> 2)] = d;
            end else begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
        end
        @(posedge CLK); #1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.dwait   = 1'b1;
        @(negedge CLK);
        chk1("after_dhit", bus.dhit, 1'b0);
        chk1("after_dREN", bus.dREN, 1'b0);
        chk1("after_dWEN", bus.dWEN, 1'b0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_hits"}, bus.hit_count, m_hits);
        chk({tag, "_miss"}, bus.miss_count, m_miss);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit_seen;
        RST           = 1'b1;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        bus.dmemaddr  = '0;
        bus.dmemstore = '0;
        bus.halt      = 1'b0;
        bus.dload     = '0;
        bus.dwait     = 1'b1;
        model_reset();
        m_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk1("rst_dhit", bus.dhit, 1'b0);
        chk1("rst_dREN", bus.dREN, 1'b0);
        chk1("rst_dWEN", bus.dWEN, 1'b0);
        chk1("rst_flushed", bus.flushed, 1'b0);
        chk("rst_dmemload", bus.dmemload, '0);
        chk("rst_daddr", bus.daddr, '0);
        chk("rst_dstore", bus.dstore, '0);
        chk_counts("rst");

        // cold miss with 3 busy cycles, then the same read hits
        do_req(1'b0, 32'h100, '0, 3);
        chk_counts("first_miss");
        do_req(1'b0, 32'h100, '0, 0);
        chk_counts("first_hit");

        // same index, different tag evicts
        do_req(1'b0, 32'h140, '0, 1);
        do_req(1'b0, 32'h100, '0, 2);
        chk_counts("conflict");
        chk("conflict_miss3", bus.miss_count, 32'd3);

        // write-through to a resident word, then read it back as a hit
        do_req(1'b1, 32'h100, 32'h1234_5678, 1);
        do_req(1'b0, 32'h100, '0, 0);
        chk_counts("wr_hit");
        // write to an uncached word does not allocate
        do_req(1'b1, 32'h200, 32'hCAFE_F00D, 0);
        do_req(1'b0, 32'h200, '0, 2);
        chk_counts("no_alloc");

        // random traffic over a small set of indices and tags
        for (int t = 0; t < 80; t++) begin
            word_t a;
            a = 32'h1000 + (word_t'($urandom_range(0, 2)) << 6)
                         + (word_t'($urandom_range(0, 3)) << 2);
            do_req($urandom_range(0, 2) == 0, a, word_t'($urandom), int'($urandom_range(0, 3)));
        end
        chk_counts("random");

        // reset during a stalled write aborts it and empties the cache
        do_req(1'b0, 32'h300, '0, 0);
        @(posedge CLK); #1;
        bus.dmemWEN   = 1'b1;
        bus.dmemaddr  = 32'h300;
        bus.dmemstore = 32'h5555_AAAA;
        bus.dwait     = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk1("stall_dWEN", bus.dWEN, 1'b1);
        @(posedge CLK); #1;
        RST         = 1'b1;
        bus.dmemWEN = 1'b0;
        @(posedge CLK); #1;
        chk1("abort_dWEN", bus.dWEN, 1'b0);
        chk1("abort_dREN", bus.dREN, 1'b0);
        chk1("abort_dhit", bus.dhit, 1'b0);
        chk("abort_hits", bus.hit_count, '0);
        chk("abort_miss", bus.miss_count, '0);
        RST = 1'b0;
        model_reset();
        do_req(1'b0, 32'h300, '0, 1);
        chk_counts("after_abort");

        // halt raised mid-load: load completes, then the cache drains
        @(posedge CLK); #1;
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h400;
        bus.dload    = mem_rd(32'h400);
        bus.dwait    = 1'b1;
        m_miss++;
        @(posedge CLK); #1;
        bus.halt = 1'b1;
        @(negedge CLK);
        chk1("halt_dREN", bus.dREN, 1'b1);
        chk1("halt_busy_flushed", bus.flushed, 1'b0);
        @(posedge CLK); #1;
        bus.dwait = 1'b0;
        @(negedge CLK);
        chk1("halt_dhit", bus.dhit, 1'b1);
        chk("halt_data", bus.dmemload, mem_rd(32'h400));
        @(posedge CLK); #1;
        bus.dmemREN = 1'b0;
        bus.dwait   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            if (bus.flushed) break;
        end
        chk1("halt_flushed", bus.flushed, 1'b1);
        chk_counts("halt");
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h300;
        hit_seen     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            hit_seen = hit_seen | bus.dhit | bus.dREN | bus.dWEN;
            chk1("halted_sticky", bus.flushed, 1'b1);
        end
        chk1("halted_ignore", hit_seen, 1'b0);
        chk_counts("halted");
        bus.dmemREN = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
